la_capture_ctrl: RTL
====================

Name: la_capture_ctrl

Overview:
Trigger and capture controller for the PCI logic analyzer. It sits between the 16-deep pre-trigger delay line and the 256x48 acquisition RAM.
- Consumes the delayed 48-bit bus sample every PCI_CLK.
- Evaluates a programmable mask/value trigger.
- Writes pre-trigger history circularly, then a programmed number of post-trigger samples.
- Reports trigger address, fill status and done to the PCI IO register file for host readout.

Parameters:
SAMPLE_W, 48, width of one bus sample
ADDR_W, 8, acquisition RAM address width (depth 2^ADDR_W)

Ports:
PCI_CLK  in  1  PCI clock; all logic in this domain
PCI_RSTn  in  1  asynchronous active-low reset
sample_in  in  SAMPLE_W  delayed bus sample, new value every cycle
cfg_mask  in  SAMPLE_W  trigger compare mask, 1 = bit compared
cfg_value  in  SAMPLE_W  trigger compare value
cfg_post  in  ADDR_W  number of post-trigger samples after the trigger sample
cmd_arm  in  1  one-cycle pulse, start acquisition
cmd_abort  in  1  one-cycle pulse, return to idle
ram_we  out  1  acquisition RAM write enable
ram_addr  out  ADDR_W  acquisition RAM write address
ram_data  out  SAMPLE_W  acquisition RAM write data
trig_addr  out  ADDR_W  RAM address holding the trigger sample
filled  out  1  write pointer has wrapped at least once since arm
busy  out  1  state is ARMED or CAPTURE
done  out  1  state is DONE
state_o  out  2  encoded state, for status register

Behaviour:
- Reset (async, PCI_RSTn=0) sets the following:
  - state=IDLE
  - ram_we=0, ram_addr=0, ram_data=0
  - trig_addr=0, filled=0, busy=0, done=0
  - wr_ptr=0, remaining=0
- The decision for a sample is taken at the PCI_CLK edge where sample_in is sampled. RAM-side outputs are registered, so latency is 1 cycle from sample_in to ram_we/ram_addr/ram_data.
- Trigger match is combinational: match = ((sample_in ^ cfg_value) & cfg_mask) == 0. A mask of all zeros matches every sample.
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE:
  - ram_we=0.
  - cmd_arm -> ARMED; wr_ptr<=0, filled<=0.
- ARMED:
  - Every cycle: ram_we<=1, ram_addr<=wr_ptr, ram_data<=sample_in, wr_ptr<=wr_ptr+1 (wraps 2^ADDR_W-1 -> 0).
  - On wrap, filled<=1 (sticky until next arm).
  - If match: trig_addr<=wr_ptr, remaining<=cfg_post, and next state is CAPTURE, or DONE if cfg_post==0.
- CAPTURE:
  - Writes as in ARMED; match is ignored.
  - If remaining==1 -> DONE; remaining<=remaining-1.
  - Exactly cfg_post samples are written after the trigger sample.
- DONE:
  - ram_we=0; wr_ptr and trig_addr are held; done=1.
  - cmd_arm -> ARMED (re-arm, clears filled).
- cmd_abort from any state -> IDLE next cycle; ram_we<=0. trig_addr, filled and wr_ptr are held.
- cmd_arm and cmd_abort in the same cycle: abort wins.
- cmd_arm in ARMED or CAPTURE is ignored.
- cfg_post is sampled only at the trigger. cfg_mask and cfg_value are used live; the software contract requires them to be stable while busy.
- Total samples written = pre-trigger samples + 1 + cfg_post. The maximum cfg_post (2^ADDR_W-1) overwrites all pre-trigger history; this is legal.
- The oldest valid sample is at wr_ptr if filled=1, otherwise at address 0. The host derives the pre-trigger count from trig_addr, wr_ptr and filled.
- Reset asserted mid-CAPTURE: immediate return to reset values. No further RAM writes until a new arm.

Decomposition:
- Shared package la_pkg holds:
  - state encoding constants (LA_IDLE, LA_ARMED, LA_CAPTURE, LA_DONE)
  - LA_SAMPLE_W=48, LA_ADDR_W=8
  - sample field offsets (AD [47:16], CBE [15:12], IRDYn 11, TRDYn 10, FRAMEn 9, DEVSELn 8, IDSEL..STOPn [7:0])
- One natural sub-module: la_trigger_match (masked compare, purely combinational). FSM, pointer and counter stay in la_capture_ctrl.

Test Plan:
1. Reset, then arm with mask=0 and cfg_post=3 -> trigger on first armed sample. trig_addr=0; writes at addresses 0..3; done=1 on the cycle after the 4th write; filled=0.
2. Mask=0xFFFF_FFFF_0000, value=0x0000_0200_0000 (AD=0x200). Drive the match at the 20th armed cycle, cfg_post=10 -> trig_addr=19; last write at address 29; exactly 30 writes; busy drops with done.
3. No match for 300 cycles, then match, cfg_post=5 -> wr_ptr wraps; filled=1; trig_addr=300 mod 256=44; writes stop after address 49.
4. cmd_abort during CAPTURE (remaining=7) -> ram_we=0 next cycle; state_o=0; trig_addr held. A subsequent arm restarts at address 0 with filled=0.
5. cmd_arm and cmd_abort pulsed together while ARMED -> IDLE. cmd_arm alone while CAPTURE -> ignored; capture count unchanged.
6. PCI_RSTn asserted asynchronously mid-CAPTURE -> all outputs 0 immediately, without waiting for a clock edge. No writes after release until cmd_arm.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the PCI logic-analyzer capture path.
// Holds the state encoding, default widths and the bus sample field layout.
package la_pkg;

  localparam int LA_SAMPLE_W = 48;
  localparam int LA_ADDR_W   = 8;

  typedef enum logic [1:0] {
    LA_IDLE    = 2'd0,
    LA_ARMED   = 2'd1,
    LA_CAPTURE = 2'd2,
    LA_DONE    = 2'd3
  } la_state_t;

  // Bit positions of the PCI signals inside one 48-bit sample
  localparam int LA_AD_MSB      = 47;
  localparam int LA_AD_LSB      = 16;
  localparam int LA_CBE_MSB     = 15;
  localparam int LA_CBE_LSB     = 12;
  localparam int LA_IRDYN_BIT   = 11;
  localparam int LA_TRDYN_BIT   = 10;
  localparam int LA_FRAMEN_BIT  = 9;
  localparam int LA_DEVSELN_BIT = 8;
  localparam int LA_CTRL_MSB    = 7;
  localparam int LA_CTRL_LSB    = 0;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Bus bundle between the IO register file / delay line (master) and the
// capture controller (slave).
interface la_capture_ctrl_if #(
  parameter int SAMPLE_W = la_pkg::LA_SAMPLE_W,
  parameter int ADDR_W   = la_pkg::LA_ADDR_W
);

  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] cfg_mask;
  logic [SAMPLE_W-1:0] cfg_value;
  logic [ADDR_W-1:0]   cfg_post;
  logic                cmd_arm;
  logic                cmd_abort;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_data;
  logic [ADDR_W-1:0]   trig_addr;
  logic                filled;
  logic                busy;
  logic                done;
  logic [1:0]          state_o;

  modport master (
    output sample_in, cfg_mask, cfg_value, cfg_post, cmd_arm, cmd_abort,
    input  ram_we, ram_addr, ram_data, trig_addr, filled, busy, done, state_o
  );

  modport slave (
    input  sample_in, cfg_mask, cfg_value, cfg_post, cmd_arm, cmd_abort,
    output ram_we, ram_addr, ram_data, trig_addr, filled, busy, done, state_o
  );

endinterface

// File: rtl/la_trigger_match.sv
// Masked equality compare of one bus sample; a zero mask matches anything.
module la_trigger_match #(
  parameter int W = la_pkg::LA_SAMPLE_W
) (
  input  logic [W-1:0] i_sample,
  input  logic [W-1:0] i_mask,
  input  logic [W-1:0] i_value,
  output logic         o_match
);

  assign o_match = (((i_sample ^ i_value) & i_mask) == '0);

endmodule

// File: rtl/la_capture_ctrl.sv
// Trigger/capture controller: circular pre-trigger fill of the acquisition
// RAM, then a programmed number of post-trigger samples.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int SAMPLE_W = LA_SAMPLE_W,
  parameter int ADDR_W   = LA_ADDR_W
) (
  input  logic            PCI_CLK,
  input  logic            PCI_RSTn,
  la_capture_ctrl_if.slave bus
);

  la_state_t           r_state;
  la_state_t           w_state_next;
  logic                w_match;
  logic                w_write;
  logic                w_arm;
  logic                w_trigger;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [SAMPLE_W-1:0] r_ram_data;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic                r_filled;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_remaining;

  la_trigger_match #(.W(SAMPLE_W)) u_match (
    .i_sample (bus.sample_in),
    .i_mask   (bus.cfg_mask),
    .i_value  (bus.cfg_value),
    .o_match  (w_match)
  );

  // Abort outranks every other command, including a simultaneous arm
  assign w_write   = !bus.cmd_abort && (r_state == LA_ARMED || r_state == LA_CAPTURE);
  assign w_arm     = !bus.cmd_abort && bus.cmd_arm && (r_state == LA_IDLE || r_state == LA_DONE);
  assign w_trigger = !bus.cmd_abort && (r_state == LA_ARMED) && w_match;

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      r_state <= LA_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.cmd_abort) begin
      w_state_next = LA_IDLE;
    end else begin
      case (r_state)
        LA_IDLE:    if (bus.cmd_arm) w_state_next = LA_ARMED;
        LA_ARMED:   if (w_match) w_state_next = (bus.cfg_post == '0) ? LA_DONE : LA_CAPTURE;
        LA_CAPTURE: if (r_remaining == ADDR_W'(1)) w_state_next = LA_DONE;
        LA_DONE:    if (bus.cmd_arm) w_state_next = LA_ARMED;
        default:    w_state_next = LA_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_trig_addr <= '0;
      r_filled    <= 1'b0;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      r_ram_we <= w_write;
      if (w_write) begin
        r_ram_addr <= r_wr_ptr;
        r_ram_data <= bus.sample_in;
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        if (&r_wr_ptr) r_filled <= 1'b1;
      end
      if (w_arm) begin
        r_wr_ptr <= '0;
        r_filled <= 1'b0;
      end
      // cfg_post is latched only here; later changes do not affect this capture
      if (w_trigger) begin
        r_trig_addr <= r_wr_ptr;
        r_remaining <= bus.cfg_post;
      end else if (w_write && r_state == LA_CAPTURE) begin
        r_remaining <= r_remaining - ADDR_W'(1);
      end
    end
  end

  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_data  = r_ram_data;
  assign bus.trig_addr = r_trig_addr;
  assign bus.filled    = r_filled;
  assign bus.busy      = (r_state == LA_ARMED) || (r_state == LA_CAPTURE);
  assign bus.done      = (r_state == LA_DONE);
  assign bus.state_o   = r_state;

endmodule
